// File: rtl/switchover_sequencer_pkg.sv
// Shared types for the A/B host switchover sequencer.
// State encoding and host select constants.
package switchover_pkg;

  typedef enum logic [1:0] {
    HOST,
    GUARD,
    RESET_STBY,
    BOOT_STBY
  } state_t;

  localparam logic HOST_A = 1'b0;
  localparam logic HOST_B = 1'b1;

endpackage

// File: rtl/switchover_sequencer_if.sv
// Heartbeat/command inputs and switch/reset/status outputs
// of the switchover sequencer.
interface switchover_sequencer_if;

  logic io_a;
  logic io_b;
  logic force_swi;
  logic com_swi;
  logic switch;
  logic reset_A;
  logic reset_B;
  logic busy;
  logic fault_A;
  logic fault_B;

  modport master (
    output io_a, io_b, force_swi, com_swi,
    input  switch, reset_A, reset_B, busy, fault_A, fault_B
  );

  modport slave (
    input  io_a, io_b, force_swi, com_swi,
    output switch, reset_A, reset_B, busy, fault_A, fault_B
  );

endinterface

// File: rtl/switchover_sequencer_heartbeat_monitor.sv
// Saturating miss counter on one CPU heartbeat level;
// healthy drops on the FAIL_CYCLES-th consecutive low sample.
module heartbeat_monitor #(
  parameter int FAIL_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic io,
  input  logic clr,
  output logic healthy
);

  localparam int W = $clog2(FAIL_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (io || clr) begin
      cnt <= '0;
    end else if (cnt != W'(FAIL_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign healthy = (cnt < W'(FAIL_CYCLES));

endmodule

// File: rtl/switchover_sequencer.sv
// Host select FSM: dead-time guarded switchover plus bounded
// reset/boot retries of the standby CPU.
module switchover_sequencer
  import switchover_pkg::*;
#(
  parameter int FAIL_CYCLES  = 16,
  parameter int GUARD_CYCLES = 8,
  parameter int RST_CYCLES   = 32,
  parameter int BOOT_CYCLES  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  switchover_sequencer_if.slave bus
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int TW = $clog2(MAX_RETRY + 1);

  state_t        state, state_d;
  logic [GW-1:0] guard_cnt, guard_cnt_d;
  logic [RW-1:0] rst_cnt, rst_cnt_d;
  logic [BW-1:0] boot_cnt, boot_cnt_d;
  logic [TW-1:0] retry, retry_d;
  logic          recover, recover_d;
  logic          switch_q, switch_d;
  logic          reset_a_q, reset_a_d;
  logic          reset_b_q, reset_b_d;
  logic          busy_q, busy_d;
  logic          fault_a_q, fault_a_d;
  logic          fault_b_q, fault_b_d;

  logic healthy_a, healthy_b;
  logic host_ok, stby_ok, stby_io, stby_fault;

  heartbeat_monitor #(.FAIL_CYCLES(FAIL_CYCLES)) u_mon_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus.io_a),
    .clr     (reset_a_q),
    .healthy (healthy_a)
  );

  heartbeat_monitor #(.FAIL_CYCLES(FAIL_CYCLES)) u_mon_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus.io_b),
    .clr     (reset_b_q),
    .healthy (healthy_b)
  );

  always_comb begin
    host_ok    = (switch_q == HOST_A) ? healthy_a : healthy_b;
    stby_ok    = (switch_q == HOST_A) ? healthy_b : healthy_a;
    stby_io    = (switch_q == HOST_A) ? bus.io_b : bus.io_a;
    stby_fault = (switch_q == HOST_A) ? fault_b_q : fault_a_q;
  end

  always_comb begin
    state_d     = state;
    guard_cnt_d = '0;
    rst_cnt_d   = '0;
    boot_cnt_d  = '0;
    retry_d     = retry;
    recover_d   = recover;
    switch_d    = switch_q;
    reset_a_d   = 1'b0;
    reset_b_d   = 1'b0;
    busy_d      = (state != HOST);
    fault_a_d   = fault_a_q;
    fault_b_d   = fault_b_q;

    unique case (state)
      HOST: begin
        if (bus.force_swi) begin
          state_d   = GUARD;
          recover_d = 1'b0;
        end else if (!host_ok && stby_ok) begin
          state_d   = GUARD;
          recover_d = 1'b1;
        end else if (bus.com_swi && stby_ok) begin
          state_d   = GUARD;
          recover_d = 1'b0;
        end else if (!stby_ok && !stby_fault &&
                     retry < TW'(MAX_RETRY)) begin
          state_d = RESET_STBY;
        end
      end
      GUARD: begin
        if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
          switch_d  = ~switch_q;
          state_d   = recover ? RESET_STBY : HOST;
          recover_d = 1'b0;
        end else begin
          guard_cnt_d = guard_cnt + 1'b1;
        end
      end
      RESET_STBY: begin
        if (rst_cnt == RW'(RST_CYCLES - 1)) begin
          state_d = BOOT_STBY;
          retry_d = retry + 1'b1;
        end else begin
          rst_cnt_d = rst_cnt + 1'b1;
        end
      end
      BOOT_STBY: begin
        if (stby_io) begin
          retry_d = '0;
          state_d = HOST;
        end else if (boot_cnt == BW'(BOOT_CYCLES - 1)) begin
          if (retry == TW'(MAX_RETRY)) begin
            if (switch_q == HOST_A) fault_b_d = 1'b1;
            else                    fault_a_d = 1'b1;
            retry_d = '0;
            state_d = HOST;
          end else begin
            state_d = RESET_STBY;
          end
        end else begin
          boot_cnt_d = boot_cnt + 1'b1;
        end
      end
      default: state_d = HOST;
    endcase

    // reset follows the standby under the post-toggle select
    if (state_d == RESET_STBY) begin
      if (switch_d == HOST_A) reset_b_d = 1'b1;
      else                    reset_a_d = 1'b1;
    end

    if (bus.io_a) fault_a_d = 1'b0;
    if (bus.io_b) fault_b_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOST;
      guard_cnt <= '0;
      rst_cnt   <= '0;
      boot_cnt  <= '0;
      retry     <= '0;
      recover   <= 1'b0;
      switch_q  <= HOST_A;
      reset_a_q <= 1'b0;
      reset_b_q <= 1'b0;
      busy_q    <= 1'b0;
      fault_a_q <= 1'b0;
      fault_b_q <= 1'b0;
    end else begin
      state     <= state_d;
      guard_cnt <= guard_cnt_d;
      rst_cnt   <= rst_cnt_d;
      boot_cnt  <= boot_cnt_d;
      retry     <= retry_d;
      recover   <= recover_d;
      switch_q  <= switch_d;
      reset_a_q <= reset_a_d;
      reset_b_q <= reset_b_d;
      busy_q    <= busy_d;
      fault_a_q <= fault_a_d;
      fault_b_q <= fault_b_d;
    end
  end

  assign bus.switch  = switch_q;
  assign bus.reset_A = reset_a_q;
  assign bus.reset_B = reset_b_q;
  assign bus.busy    = busy_q;
  assign bus.fault_A = fault_a_q;
  assign bus.fault_B = fault_b_q;

endmodule

// File: tb/tb_switchover_sequencer.sv
// Directed bench for switchover_sequencer with short timing
// parameters (FAIL=4 GUARD=2 RST=3 BOOT=10 MAX_RETRY=2).
module tb_switchover_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic seen;

  switchover_sequencer_if bus ();

  switchover_sequencer #(
    .FAIL_CYCLES  (4),
    .GUARD_CYCLES (2),
    .RST_CYCLES   (3),
    .BOOT_CYCLES  (10),
    .MAX_RETRY    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got,
                       input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.io_a      = 1'b1;
    bus.io_b      = 1'b1;
    bus.force_swi = 1'b0;
    bus.com_swi   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    do_reset();
    check("rst_switch", bus.switch, 1'b0);
    check("rst_reset_a", bus.reset_A, 1'b0);
    check("rst_reset_b", bus.reset_B, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_fault_a", bus.fault_A, 1'b0);
    check("rst_fault_b", bus.fault_B, 1'b0);

    // host A heartbeat lost: decision on edge 5, toggle on edge 7
    bus.io_a = 1'b0;
    step(6);
    check("hf_sw_hold", bus.switch, 1'b0);
    check("hf_busy", bus.busy, 1'b1);
    step(1);
    check("hf_sw_tog", bus.switch, 1'b1);
    check("hf_rsta_on", bus.reset_A, 1'b1);
    step(2);
    check("hf_rsta_3rd", bus.reset_A, 1'b1);
    step(1);
    check("hf_rsta_off", bus.reset_A, 1'b0);
    check("hf_rstb_off", bus.reset_B, 1'b0);
    bus.io_a = 1'b1;
    step(2);
    check("hf_idle", bus.busy, 1'b0);
    check("hf_fault_a", bus.fault_A, 1'b0);
    check("hf_sw_keep", bus.switch, 1'b1);

    // dead standby A: two reset/boot rounds then fault
    bus.io_a = 1'b0;
    step(5);
    check("ds_p1_on", bus.reset_A, 1'b1);
    step(3);
    check("ds_p1_off", bus.reset_A, 1'b0);
    step(9);
    check("ds_boot1", bus.reset_A, 1'b0);
    check("ds_busy", bus.busy, 1'b1);
    step(1);
    check("ds_p2_on", bus.reset_A, 1'b1);
    step(3);
    check("ds_p2_off", bus.reset_A, 1'b0);
    step(9);
    check("ds_no_fault", bus.fault_A, 1'b0);
    step(1);
    check("ds_fault", bus.fault_A, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen |= bus.reset_A;
    end
    check("ds_no_rsta", seen, 1'b0);
    check("ds_idle", bus.busy, 1'b0);
    bus.io_a = 1'b1;
    step(1);
    check("ds_fault_clr", bus.fault_A, 1'b0);

    // forced switch with standby B heartbeat low
    do_reset();
    seen = 1'b0;
    bus.io_b      = 1'b0;
    bus.force_swi = 1'b1;
    step(1);
    seen |= bus.reset_B;
    bus.force_swi = 1'b0;
    step(1);
    seen |= bus.reset_B;
    check("fs_sw_hold", bus.switch, 1'b0);
    step(1);
    seen |= bus.reset_B;
    check("fs_sw_tog", bus.switch, 1'b1);
    bus.io_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen |= bus.reset_B;
    end
    check("fs_no_rstb", seen, 1'b0);
    check("fs_sw_keep", bus.switch, 1'b1);

    // com_swi gated by unhealthy standby B
    do_reset();
    bus.io_b = 1'b0;
    step(4);
    bus.com_swi = 1'b1;
    step(1);
    bus.com_swi = 1'b0;
    check("cg_sw_hold", bus.switch, 1'b0);
    check("cg_rstb_on", bus.reset_B, 1'b1);
    step(1);
    check("cg_rstb_2nd", bus.reset_B, 1'b1);
    bus.io_b = 1'b1;
    step(2);
    check("cg_rstb_off", bus.reset_B, 1'b0);
    step(2);
    check("cg_idle", bus.busy, 1'b0);
    check("cg_no_guard", bus.switch, 1'b0);
    bus.com_swi = 1'b1;
    step(1);
    bus.com_swi = 1'b0;
    step(1);
    check("cg_sw_hold2", bus.switch, 1'b0);
    step(1);
    check("cg_sw_tog", bus.switch, 1'b1);

    // force_swi during RESET_STBY of standby A is dropped
    bus.io_a = 1'b0;
    step(5);
    check("dr_rsta_on", bus.reset_A, 1'b1);
    bus.force_swi = 1'b1;
    step(1);
    bus.force_swi = 1'b0;
    step(1);
    bus.io_a = 1'b1;
    step(5);
    check("dr_sw_keep", bus.switch, 1'b1);
    check("dr_idle", bus.busy, 1'b0);

    // async reset in the middle of a reset_A pulse
    bus.io_a = 1'b0;
    step(6);
    check("mr_rsta_on", bus.reset_A, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_rsta_clr", bus.reset_A, 1'b0);
    check("mr_sw_clr", bus.switch, 1'b0);
    check("mr_busy_clr", bus.busy, 1'b0);
    bus.io_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("mr_idle", bus.busy, 1'b0);
    check("mr_sw", bus.switch, 1'b0);
    check("mr_rsta", bus.reset_A, 1'b0);
    check("mr_rstb", bus.reset_B, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
